r_uart_t_uart: RTL and testbench
================================

R_UART_T_UART -- requirements
Module: r_uart_t_uart

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal values are 4 or more.
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_data_in, input, width 1: serial receive line, idle high.
REQ-005 The block SHALL have port rx_data_out, output, width 8: last correctly received byte.
REQ-006 The block SHALL have port rx_data_valid, output, width 1: one-cycle pulse when rx_data_out updates.
REQ-007 The block SHALL have port tx_start, input, width 1: request to transmit tx_data_in.
REQ-008 The block SHALL have port tx_data_in, input, width 8: byte to transmit.
REQ-009 The block SHALL have port tx_data_out, output, width 1: serial transmit line, idle high.
REQ-010 The block SHALL have port tx_ready, output, width 1: high when the transmitter is idle and accepts tx_start.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1; each bit lasts CLKS_PER_BIT cycles.
REQ-012 The receiver SHALL pass rx_data_in through a 2-flop synchronizer before use; this adds 2 cycles of latency.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA, STOP; it leaves IDLE on a synchronized high-to-low transition.
REQ-014 In START, the receiver SHALL resample the line after CLKS_PER_BIT/2 cycles (integer division); if the line is high, the frame is a glitch and the FSM SHALL return to IDLE without output.
REQ-015 The receiver SHALL sample each data bit and the stop bit at its bit center, i.e. every CLKS_PER_BIT cycles after the start-bit center.
REQ-016 If the stop bit samples 1, the receiver SHALL load rx_data_out and pulse rx_data_valid high for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-017 If the stop bit samples 0 (framing error), the receiver SHALL discard the byte, keep rx_data_out, issue no rx_data_valid pulse, and wait in IDLE for the line to go high before detecting a new start.
REQ-018 rx_data_out SHALL hold its value between frames.
REQ-019 The transmitter FSM SHALL have states IDLE, START, DATA, STOP; tx_ready = 1 only in IDLE.
REQ-020 In IDLE with tx_start = 1 at a clock edge, the transmitter SHALL latch tx_data_in, drive tx_ready low, and drive tx_data_out low (start bit) from the next cycle.
REQ-021 The transmitter SHALL drive tx_data_out for exactly CLKS_PER_BIT cycles per bit, sending start, data[0]..data[7], then stop (1), all from the latched byte.
REQ-022 After the stop bit, the transmitter SHALL return to IDLE with tx_ready = 1 for at least one cycle; if tx_start is high in that cycle, the next frame SHALL begin on the following cycle (back-to-back period: 10*CLKS_PER_BIT + 1 cycles).
REQ-023 tx_start asserted while tx_ready = 0 SHALL be ignored; changes on tx_data_in during a frame SHALL NOT affect the frame in progress.
REQ-024 The receiver and transmitter SHALL operate independently and concurrently, and share no state.

Reset
REQ-025 While reset = 0, the block SHALL force: rx_data_out = 8'h00, rx_data_valid = 0, tx_data_out = 1, tx_ready = 1, both FSMs in IDLE, and all counters and synchronizer flops cleared (synchronizer flops to 1).
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately: tx_data_out returns high asynchronously and the receiver does not output the partial byte.

Verification
REQ-027 Reset then idle, with CLKS_PER_BIT = 4 -> tx_data_out = 1, tx_ready = 1, rx_data_valid = 0, rx_data_out = 8'h00.
REQ-028 Receive 8'hA5 with a good stop bit -> exactly one rx_data_valid pulse, rx_data_out = 8'hA5, pulse within 2 + 9.5*CLKS_PER_BIT + 2 cycles of the start edge.
REQ-029 Pulse tx_start with tx_data_in = 8'h3C -> tx_data_out carries bits 0,0,0,1,1,1,1,0,0,1 at 4 cycles each; tx_ready is low for 40 cycles.
REQ-030 Hold tx_start high continuously -> back-to-back frames every 41 cycles; a change of tx_data_in mid-frame appears only in the next frame.
REQ-031 Receive a frame with stop bit = 0, then a 1-cycle low glitch -> no rx_data_valid pulse, and rx_data_out keeps its previous value.
REQ-032 Loop tx_data_out back to rx_data_in and send 8'hFF, 8'h00, 8'h81 -> rx_data_out matches each byte in order, with one rx_data_valid pulse per byte.

Source files
------------

// File: rtl/r_uart_t_uart.sv
`timescale 1ns/1ps
// 8N1 UART: independent receiver (2-flop synchronized, center sampled) and transmitter.
// CLKS_PER_BIT clk cycles per serial bit; legal values are 4 or more.
module r_uart_t_uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_data_in,
    output logic [7:0] rx_data_out,
    output logic       rx_data_valid,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    output logic       tx_data_out,
    output logic       tx_ready
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- receiver ----------------
    logic [1:0]    rx_sync_q;
    logic          rx_prev_q;
    logic          rx_s;
    state_t        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_d;
    logic          rx_valid_d;

    assign rx_s = rx_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync_q     <= 2'b11;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_data_out   <= '0;
            rx_data_valid <= 1'b0;
        end else begin
            rx_sync_q     <= {rx_sync_q[0], rx_data_in};
            rx_prev_q     <= rx_s;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_out   <= rx_data_d;
            rx_data_valid <= rx_valid_d;
        end
    end

    // Start needs a high-to-low edge, so a line held low after a framing error is ignored.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_out;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = START;
                    rx_cnt_d   = '0;
                end
            end
            START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = IDLE;
                    if (rx_s) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ---------------- transmitter ----------------
    state_t        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_out_d;
    logic          tx_ready_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q  <= IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_data_out <= 1'b1;
            tx_ready    <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_data_out <= tx_out_d;
            tx_ready    <= tx_ready_d;
        end
    end

    // Line and ready are derived from the next state so the registered outputs track it.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b0;
        case (tx_state_q)
            IDLE: begin
                if (tx_start) begin
                    tx_state_d = START;
                    tx_shift_d = tx_data_in;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = IDLE;
        endcase

        case (tx_state_d)
            IDLE:    begin tx_out_d = 1'b1; tx_ready_d = 1'b1; end
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = tx_shift_d[0];
            default: tx_out_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_r_uart_t_uart.sv
`timescale 1ns/1ps
// Directed bench for r_uart_t_uart at CLKS_PER_BIT = 4: RX, TX, back-to-back, framing, loopback, reset.
module tb_r_uart_t_uart;

    localparam int unsigned C = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_data_in;
    logic [7:0] rx_data_out;
    logic       rx_data_valid;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       tx_data_out;
    logic       tx_ready;

    logic       rx_drv;
    logic       loop;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt  = 0;
    int vcyc  = 0;

    assign rx_data_in = loop ? tx_data_out : rx_drv;

    r_uart_t_uart #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data_in   (rx_data_in),
        .rx_data_out  (rx_data_out),
        .rx_data_valid(rx_data_valid),
        .tx_start     (tx_start),
        .tx_data_in   (tx_data_in),
        .tx_data_out  (tx_data_out),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_data_valid === 1'b1) begin
            vcnt = vcnt + 1;
            vcyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame on rx_drv starting at a falling clock edge.
    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (C) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int         v0;
        int         t0;
        int         low;
        int         rdy;
        int         first;
        logic [9:0] frame;
        logic [9:0] fr0;
        logic [9:0] fr1;
        logic [7:0] lb [3];

        reset = 1'b0; rx_drv = 1'b1; loop = 1'b0; tx_start = 1'b0; tx_data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", 32'(tx_data_out), 32'h1);
        chk("rst_tx_ready", 32'(tx_ready), 32'h1);
        chk("rst_rx_valid", 32'(rx_data_valid), 32'h0);
        chk("rst_rx_data", 32'(rx_data_out), 32'h00);

        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_tx_out", 32'(tx_data_out), 32'h1);
        chk("idle_tx_ready", 32'(tx_ready), 32'h1);
        chk("idle_rx_valid_cnt", 32'(vcnt), 32'h0);
        chk("idle_rx_data", 32'(rx_data_out), 32'h00);

        // Receive 0xA5 with a good stop bit.
        v0 = vcnt; t0 = cyc;
        rx_send(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        chk("rx_a5_pulses", 32'(vcnt - v0), 32'd1);
        chk("rx_a5_data", 32'(rx_data_out), 32'hA5);
        chk("rx_a5_latency_ok", 32'((vcyc - t0) <= 42), 32'd1);

        // Transmit 0x3C; a tx_start while busy must be ignored.
        @(negedge clk); tx_start = 1'b1; tx_data_in = 8'h3C;
        @(negedge clk); tx_start = 1'b0;
        frame = '0; low = 0;
        for (int i = 0; i < 50; i++) begin
            if (i < 40 && (i % 4) == 1) frame[i / 4] = tx_data_out;
            if (tx_ready === 1'b0) low++;
            if (i == 10) begin tx_start = 1'b1; tx_data_in = 8'hFF; end
            if (i == 11) tx_start = 1'b0;
            @(negedge clk);
        end
        chk("tx_3c_frame", 32'(frame), 32'h278);
        chk("tx_3c_ready_low", 32'(low), 32'd40);
        chk("tx_after_idle", 32'(tx_data_out), 32'h1);

        // Back-to-back with tx_start held; data change mid-frame lands in the next frame.
        tx_start = 1'b1; tx_data_in = 8'h55;
        @(negedge clk);
        fr0 = '0; fr1 = '0; rdy = 0; first = -1;
        for (int i = 0; i < 122; i++) begin
            if ((i % 41) < 40 && ((i % 41) % 4) == 1) begin
                if (i / 41 == 0) fr0[(i % 41) / 4] = tx_data_out;
                if (i / 41 == 1) fr1[(i % 41) / 4] = tx_data_out;
            end
            if (tx_ready === 1'b1) begin
                rdy++;
                if (first < 0) first = i;
            end
            if (i == 20) tx_data_in = 8'hA3;
            @(negedge clk);
        end
        tx_start = 1'b0;
        repeat (50) @(negedge clk);
        chk("b2b_frame0", 32'(fr0), 32'h2AA);
        chk("b2b_frame1", 32'(fr1), 32'h346);
        chk("b2b_ready_cycles", 32'(rdy), 32'd2);
        chk("b2b_first_ready", 32'(first), 32'd40);

        // Framing error followed by a one-cycle glitch.
        v0 = vcnt;
        rx_send(8'h12, 1'b0);
        repeat (6) @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        chk("ferr_pulses", 32'(vcnt - v0), 32'd0);
        chk("ferr_data_kept", 32'(rx_data_out), 32'hA5);

        // Loopback.
        loop = 1'b1;
        lb[0] = 8'hFF; lb[1] = 8'h00; lb[2] = 8'h81;
        for (int k = 0; k < 3; k++) begin
            v0 = vcnt;
            tx_data_in = lb[k]; tx_start = 1'b1;
            @(negedge clk); tx_start = 1'b0;
            repeat (55) @(negedge clk);
            chk($sformatf("loop%0d_pulses", k), 32'(vcnt - v0), 32'd1);
            chk($sformatf("loop%0d_data", k), 32'(rx_data_out), 32'(lb[k]));
        end

        // Reset mid-frame aborts both directions.
        v0 = vcnt;
        tx_data_in = 8'h00; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midframe_tx_low", 32'(tx_data_out), 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("abort_tx_out", 32'(tx_data_out), 32'h1);
        chk("abort_tx_ready", 32'(tx_ready), 32'h1);
        chk("abort_rx_data", 32'(rx_data_out), 32'h00);
        @(negedge clk); reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_rx_pulse", 32'(vcnt - v0), 32'd0);
        chk("abort_tx_idle", 32'(tx_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
